level_meter_peak_hold: RTL and testbench
========================================

# level_meter_peak_hold

Display stage directly downstream of `section_min_max_buffer`. It accepts the peak-to-peak amplitude stream on a valid/ready handshake and quantises each value to a logarithmic bar level. It then applies peak-hold with timed decay and presents the current level, held peak and a thermometer bar pattern to the LED/display driver.

## Interface
- `width`, 16, amplitude bit width (matches upstream `o_value`).
- `level_count`, 8, number of bar segments; 1 ≤ level_count ≤ width.
- `hold_samples`, 4, accepted samples the peak is held after a new peak; ≥ 1.
- `decay_samples`, 2, accepted samples per one-segment peak decay after hold expires; ≥ 1.
- LW = $clog2(level_count+1), the width of the level outputs.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  reset; synchronous, active-low (0 = reset).
- `i_valid`  in  1  input amplitude valid.
- `i_ready`  out  1  block can accept input.
- `i_value`  in  width  unsigned peak-to-peak amplitude.
- `o_valid`  out  1  output registers hold an unconsumed result.
- `o_ready`  in  1  downstream accepts result.
- `o_level`  out  LW  current quantised level, 0..level_count.
- `o_peak`  out  LW  held peak level, 0..level_count.
- `o_bar`  out  level_count  thermometer bar plus peak dot.

## Operation
- **Threshold:** T_k = 1 << (width − level_count + k − 1), for k = 1..level_count.
- **Level:** L = count of k with i_value ≥ T_k. This equals, combinationally, the MSB position of i_value clamped into the segment range.
- **Example levels, width=16, level_count=8:**
  - 0x0000 and 0x00FF → 0.
  - 0x0100 → 1.
  - 0x1111 → 5.
  - 0x3333 → 6.
  - 0x8888 and 0xFFFF → 8.
- **Internal state:** H (held peak, LW bits), hc (hold counter), dc (decay counter). Each counter is sized $clog2(param+1).
- **Update per accepted input, exactly one branch applies:**
  - L ≥ H: H←L, hc←hold_samples, dc←decay_samples. Equality also reloads.
  - Else if hc ≠ 0: hc←hc−1.
  - Else if dc > 1: dc←dc−1.
  - Else: H←H−1, dc←decay_samples. H never drops below L in this branch, because L < H.
- **Output register:** on accept, load o_level←L, o_peak←new H, o_valid←1.
- **o_bar:** bit (k−1) is set for every k ≤ L. Bit (H−1) is additionally set when H > 0. o_bar is all zeros when L = H = 0.
- **Held output:** while o_valid=1 and o_ready=0, all outputs stay stable and no state updates.

## Timing
- `i_ready` = reset & (!o_valid | o_ready), combinational. This gives a one-deep pipeline with full throughput of one sample per clock when o_ready=1.
- **Accept:** occurs at a rising edge with i_valid & i_ready.
- **Latency:** 1 cycle. Results appear on the outputs, with o_valid=1, after the accepting edge.
- **Consume:** occurs at an edge with o_valid & o_ready.
  - Consume and accept in the same edge: the outputs are replaced by the new result and o_valid stays 1.
  - Consume with no accept: o_valid←0 and the data outputs keep their last value.
- **Reset (reset=0 at an edge):**
  - o_valid, o_level, o_peak, o_bar, H, hc and dc all ← 0.
  - i_ready is 0 while reset=0.
  - Reset mid-transfer discards any pending result and clears the held peak.
- **Hold behaviour:** a peak is held for hold_samples further accepted samples, then falls by one level every decay_samples accepted samples. Decay is measured in samples, not clocks; stalls do not advance it.

## Test plan
- **Reset:** hold reset=0 for 2 clocks with o_ready=1 → o_valid=0, o_level=0, o_peak=0, o_bar=0, i_ready=0. After release, i_ready=1.
- **Quantisation sweep:** feed 0x0000, 0x00FF, 0x0100, 0x1111, 0x3333, 0x8888, 0xFFFF → o_level = 0, 0, 1, 5, 6, 8, 8, each one cycle after its accept.
- **Hold and decay** (hold=4, decay=2): feed 0x3333, then nine 0x0000 → o_peak sequence 6,6,6,6,6,6,5,5,4,4. For the first sample o_bar = 8'b0011_1111; for the tenth, o_bar = 8'b0000_1000.
- **New peak during decay:** after the above, feed 0x8888 → o_peak=8 and hold restarts. Then feed 0x1111 ×5 → o_peak stays 8 for the first 4, and the 5th gives o_peak=8 with dc=1.
- **Backpressure:** o_ready=0 with o_valid=1 → i_ready=0 and outputs frozen for N clocks; a changing i_value has no effect. With o_ready=1 and i_valid=1 in the same cycle → the next result loads and o_valid stays 1.
- **Reset mid-decay:** with o_peak=5, pulse reset=0 for one clock → all outputs 0. Then feed 0x0100 → o_level=1, o_peak=1, o_bar=8'b0000_0001.

Source files
------------

// File: rtl/level_meter_peak_hold.sv
// Logarithmic bar-level meter with peak-hold and timed decay, one-deep
// valid/ready pipeline between the min/max buffer and the display driver.
module level_meter_peak_hold #(
    parameter int width         = 16,
    parameter int level_count   = 8,
    parameter int hold_samples  = 4,
    parameter int decay_samples = 2,
    parameter int LW            = $clog2(level_count + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [width-1:0]       i_value,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [LW-1:0]          o_level,
    output logic [LW-1:0]          o_peak,
    output logic [level_count-1:0] o_bar
);

    localparam int HCW = $clog2(hold_samples + 1);
    localparam int DCW = $clog2(decay_samples + 1);

    logic [LW-1:0]          r_peak;
    logic [HCW-1:0]         r_hc;
    logic [DCW-1:0]         r_dc;
    logic [LW-1:0]          r_level;
    logic [level_count-1:0] r_bar;
    logic                   r_valid;

    logic [LW-1:0]          w_level;
    logic [LW-1:0]          w_peakNext;
    logic [HCW-1:0]         w_hcNext;
    logic [DCW-1:0]         w_dcNext;
    logic [level_count-1:0] w_bar;
    logic                   w_accept;

    assign i_ready  = reset & (!r_valid | o_ready);
    assign w_accept = i_valid & i_ready;

    // Segment k lights when any bit at or above its threshold position is set.
    always_comb begin
        w_level = '0;
        for (int k = 1; k <= level_count; k++) begin
            if ((i_value >> (width - level_count + k - 1)) != '0) begin
                w_level = w_level + LW'(1);
            end
        end
    end

    always_comb begin
        w_peakNext = r_peak;
        w_hcNext   = r_hc;
        w_dcNext   = r_dc;
        if (w_level >= r_peak) begin
            w_peakNext = w_level;
            w_hcNext   = HCW'(hold_samples);
            w_dcNext   = DCW'(decay_samples);
        end else if (r_hc != '0) begin
            w_hcNext = r_hc - HCW'(1);
        end else if (r_dc > DCW'(1)) begin
            w_dcNext = r_dc - DCW'(1);
        end else begin
            w_peakNext = r_peak - LW'(1);
            w_dcNext   = DCW'(decay_samples);
        end
    end

    always_comb begin
        w_bar = '0;
        for (int k = 0; k < level_count; k++) begin
            w_bar[k] = (k < int'(w_level)) ||
                       ((w_peakNext != '0) && (k == int'(w_peakNext) - 1));
        end
    end

    // Peak state only moves on accepted samples, so stalls freeze the decay.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_peak  <= '0;
            r_hc    <= '0;
            r_dc    <= '0;
            r_level <= '0;
            r_bar   <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_peak  <= w_peakNext;
            r_hc    <= w_hcNext;
            r_dc    <= w_dcNext;
            r_level <= w_level;
            r_bar   <= w_bar;
            r_valid <= 1'b1;
        end else if (r_valid && o_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_level = r_level;
    assign o_peak  = r_peak;
    assign o_bar   = r_bar;

endmodule

// File: tb/tb_level_meter_peak_hold.sv
// Directed scoreboard bench for level_meter_peak_hold: a reference model pushes
// expected results as samples are driven and they are popped on each output.
module tb_level_meter_peak_hold;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_value = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [3:0]  o_level;
    logic [3:0]  o_peak;
    logic [7:0]  o_bar;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] peak;
        logic [7:0] bar;
    } exp_t;

    exp_t expQ[$];
    exp_t lastExp;
    int   compared = 0;
    int   mismatched = 0;
    int   mPeak = 0;
    int   mHc = 0;
    int   mDc = 0;

    level_meter_peak_hold dut (
        .clk    (clk),
        .reset  (reset),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_value(i_value),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_level(o_level),
        .o_peak (o_peak),
        .o_bar  (o_bar)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int levelOf(input logic [15:0] v);
        int lvl = 0;
        for (int k = 1; k <= 8; k++) begin
            if (32'(v) >= (32'd1 << (16 - 8 + k - 1))) lvl++;
        end
        return lvl;
    endfunction

    function automatic logic [7:0] barOf(input int lvl, input int pk);
        logic [7:0] b = '0;
        for (int k = 1; k <= lvl; k++) b[k-1] = 1'b1;
        if (pk > 0) b[pk-1] = 1'b1;
        return b;
    endfunction

    task automatic modelReset();
        mPeak = 0;
        mHc = 0;
        mDc = 0;
        expQ.delete();
    endtask

    task automatic modelAccept(input logic [15:0] v);
        int   lvl;
        exp_t e;
        lvl = levelOf(v);
        if (lvl >= mPeak) begin
            mPeak = lvl; mHc = 4; mDc = 2;
        end else if (mHc != 0) begin
            mHc--;
        end else if (mDc > 1) begin
            mDc--;
        end else begin
            mPeak--; mDc = 2;
        end
        e.level = 4'(lvl);
        e.peak  = 4'(mPeak);
        e.bar   = barOf(lvl, mPeak);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checkVal({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        lastExp = e;
        checkVal({tag, "_valid"}, 32'(o_valid), 32'd1);
        checkVal({tag, "_level"}, 32'(o_level), 32'(e.level));
        checkVal({tag, "_peak"},  32'(o_peak),  32'(e.peak));
        checkVal({tag, "_bar"},   32'(o_bar),   32'(e.bar));
    endtask

    task automatic applyStimulus(input logic [15:0] v, input string tag);
        int waitCycles = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_value = v;
        #1;
        while (!i_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!i_ready) begin
            checkVal({tag, "_iready_timeout"}, 32'd0, 32'd1);
            i_valid = 1'b0;
            return;
        end
        modelAccept(v);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        checkOutput(tag);
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        i_valid = 1'b0;
        modelReset();
        repeat (cycles) @(posedge clk);
        #1;
        checkVal("rst_iready", 32'(i_ready), 32'd0);
        checkVal("rst_valid",  32'(o_valid), 32'd0);
        checkVal("rst_level",  32'(o_level), 32'd0);
        checkVal("rst_peak",   32'(o_peak),  32'd0);
        checkVal("rst_bar",    32'(o_bar),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("rst_release_iready", 32'(i_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] sweep[7];
        int          sweepLvl[7];
        int          decayPeak[10];

        sweep    = '{16'h0000, 16'h00FF, 16'h0100, 16'h1111, 16'h3333, 16'h8888, 16'hFFFF};
        sweepLvl = '{0, 0, 1, 5, 6, 8, 8};
        decayPeak = '{6, 6, 6, 6, 6, 6, 5, 5, 4, 4};

        applyReset(2);

        // Quantisation sweep against the documented example levels.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(sweep[i], $sformatf("sweep%0d", i));
            checkVal($sformatf("sweep%0d_doc_level", i), 32'(o_level), 32'(sweepLvl[i]));
        end

        // Hold then decay.
        applyReset(1);
        applyStimulus(16'h3333, "hold0");
        checkVal("hold0_doc_bar", 32'(o_bar), 32'h3F);
        checkVal("hold0_doc_peak", 32'(o_peak), 32'(decayPeak[0]));
        for (int i = 1; i < 10; i++) begin
            applyStimulus(16'h0000, $sformatf("decay%0d", i));
            checkVal($sformatf("decay%0d_doc_peak", i), 32'(o_peak), 32'(decayPeak[i]));
        end
        checkVal("decay9_doc_bar", 32'(o_bar), 32'h08);

        // New peak during decay restarts the hold.
        applyStimulus(16'h8888, "newpeak");
        checkVal("newpeak_doc_peak", 32'(o_peak), 32'd8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h1111, $sformatf("rehold%0d", i));
            checkVal($sformatf("rehold%0d_doc_peak", i), 32'(o_peak), 32'd8);
        end
        checkVal("rehold4_doc_bar", 32'(o_bar), 32'h9F);

        // Backpressure: outputs frozen, input ignored while stalled.
        @(negedge clk);
        o_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_value = 16'(16'h0100 << i);
            #1;
            checkVal($sformatf("stall%0d_iready", i), 32'(i_ready), 32'd0);
            @(negedge clk);
            checkVal($sformatf("stall%0d_valid", i), 32'(o_valid), 32'd1);
            checkVal($sformatf("stall%0d_level", i), 32'(o_level), 32'(lastExp.level));
            checkVal($sformatf("stall%0d_peak", i),  32'(o_peak),  32'(lastExp.peak));
            checkVal($sformatf("stall%0d_bar", i),   32'(o_bar),   32'(lastExp.bar));
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        applyStimulus(16'hFFFF, "consume_accept");
        applyStimulus(16'h0000, "back2back");

        // Consume with no accept drops o_valid but keeps data.
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        checkVal("drain_valid", 32'(o_valid), 32'd0);
        checkVal("drain_level", 32'(o_level), 32'(lastExp.level));
        checkVal("drain_peak",  32'(o_peak),  32'(lastExp.peak));

        // Reset mid-decay, then a fresh minimum-level sample.
        applyReset(1);
        applyStimulus(16'h1111, "pre_rst");
        applyStimulus(16'h0000, "pre_rst_decay");
        checkVal("pre_rst_peak", 32'(o_peak), 32'd5);
        applyReset(1);
        applyStimulus(16'h0100, "post_rst");
        checkVal("post_rst_doc_level", 32'(o_level), 32'd1);
        checkVal("post_rst_doc_peak",  32'(o_peak),  32'd1);
        checkVal("post_rst_doc_bar",   32'(o_bar),   32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
